// File: rtl/ompss_lock_arbiter.sv
// ompss_lock_arbiter
// -----------------------------------------------------------------------------
// Mutual-exclusion lock table shared by the FPGA accelerators. The block sits
// in the OmpSs Manager as hardware resource 0x15. Accelerators send LOCK and
// UNLOCK commands. A LOCK is answered with an OK or REJECT acknowledgement. An
// UNLOCK is not answered. Commands are served one at a time, in the order in
// which they are accepted.
//
// Ports
//   clk, rstn          clock; asynchronous active-low reset
//   cmd_in_*           command stream: tdata[7:0] code, tdata[15:8] lock ID,
//                      tid = issuing accelerator
//   ack_out_*          acknowledgement stream: tdata[7:0] ack code,
//                      tdata[15:8] lock ID, tdest = requester, tid = 0x15
//   locks_held         number of locks currently owned
//   err                sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module ompss_lock_arbiter #(
  parameter int NUM_LOCKS = 16,
  parameter int ACC_BITS  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [63:0]         cmd_in_tdata,
  input  logic [ACC_BITS-1:0] cmd_in_tid,
  input  logic                cmd_in_tvalid,
  output logic                cmd_in_tready,
  output logic [63:0]         ack_out_tdata,
  output logic [ACC_BITS-1:0] ack_out_tdest,
  output logic [4:0]          ack_out_tid,
  output logic                ack_out_tvalid,
  input  logic                ack_out_tready,
  output logic [8:0]          locks_held,
  output logic                err
);

  localparam int         IDX_W       = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam logic [8:0] NUM_LOCKS_W = 9'(NUM_LOCKS);
  localparam logic [7:0] CODE_LOCK   = 8'h04;
  localparam logic [7:0] CODE_UNLOCK = 8'h06;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_reg;
  logic                  tready_reg;
  logic                  ack_valid_reg;
  logic [63:0]           ack_data_reg;
  logic [ACC_BITS-1:0]   ack_dest_reg;
  logic [8:0]            locks_reg;
  logic                  err_reg;
  logic [7:0]            code_reg;
  logic [7:0]            id_reg;
  logic [ACC_BITS-1:0]   tid_reg;

  logic [NUM_LOCKS-1:0]  valid_vec;
  logic [ACC_BITS-1:0]   owner_arr [NUM_LOCKS];
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  entry_valid;
  logic                  owner_match;
  logic                  is_lock;
  logic                  is_unlock;
  logic                  grant;
  logic                  release_ok;
  logic                  proto_err;

  // Only the code and lock-ID bytes of a command carry meaning.
  logic unused_tdata_bits;
  assign unused_tdata_bits = ^cmd_in_tdata[63:16];

  // The full 8-bit ID is range-checked. It is never truncated to the index
  // width, so an ID such as 0x10 cannot alias entry 0 when NUM_LOCKS is 16.
  assign idx         = id_reg[IDX_W-1:0];
  assign in_range    = {1'b0, id_reg} < NUM_LOCKS_W;
  assign entry_valid = in_range && valid_vec[idx];
  assign owner_match = owner_arr[idx] == tid_reg;
  assign is_lock     = code_reg == CODE_LOCK;
  assign is_unlock   = code_reg == CODE_UNLOCK;

  assign grant      = (state_reg == EXEC) && is_lock && in_range && !entry_valid;
  assign release_ok = (state_reg == EXEC) && is_unlock && entry_valid && owner_match;
  assign proto_err  = (state_reg == EXEC) &&
                      ((is_lock && !in_range) ||
                       (is_unlock && !release_ok) ||
                       (!is_lock && !is_unlock));

  // Lock table entries. Each entry is its own register slice so that reset
  // can clear the whole table in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOCKS; gi++) begin : g_entry
      logic                valid_reg;
      logic [ACC_BITS-1:0] owner_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          valid_reg <= 1'b0;
          owner_reg <= '0;
        end else if (grant && (idx == IDX_W'(gi))) begin
          valid_reg <= 1'b1;
          owner_reg <= tid_reg;
        end else if (release_ok && (idx == IDX_W'(gi))) begin
          valid_reg <= 1'b0;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign owner_arr[gi] = owner_reg;
    end
  endgenerate

  // Control FSM. cmd_in_tready is registered. It rises on the first edge
  // after reset, and again on every edge that returns the FSM to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      tready_reg    <= 1'b0;
      ack_valid_reg <= 1'b0;
      ack_data_reg  <= '0;
      ack_dest_reg  <= '0;
      locks_reg     <= '0;
      err_reg       <= 1'b0;
      code_reg      <= '0;
      id_reg        <= '0;
      tid_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tready_reg && cmd_in_tvalid) begin
            code_reg   <= cmd_in_tdata[7:0];
            id_reg     <= cmd_in_tdata[15:8];
            tid_reg    <= cmd_in_tid;
            tready_reg <= 1'b0;
            state_reg  <= EXEC;
          end else begin
            tready_reg <= 1'b1;
          end
        end

        EXEC: begin
          if (proto_err) begin
            err_reg <= 1'b1;
          end
          if (is_lock) begin
            // Ack code 0x01 = OK, 0x00 = REJECT (held or out of range).
            ack_valid_reg <= 1'b1;
            ack_data_reg  <= {48'h0, id_reg, 7'h0, grant};
            ack_dest_reg  <= tid_reg;
            state_reg     <= RESP;
            if (grant) begin
              locks_reg <= locks_reg + 9'd1;
            end
          end else begin
            tready_reg <= 1'b1;
            state_reg  <= IDLE;
            if (release_ok) begin
              locks_reg <= locks_reg - 9'd1;
            end
          end
        end

        RESP: begin
          if (ack_out_tready) begin
            ack_valid_reg <= 1'b0;
            tready_reg    <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_in_tready  = tready_reg;
  assign ack_out_tvalid = ack_valid_reg;
  assign ack_out_tdata  = ack_data_reg;
  assign ack_out_tdest  = ack_dest_reg;
  assign ack_out_tid    = 5'h15;
  assign locks_held     = locks_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_ompss_lock_arbiter.sv
// Directed testbench for ompss_lock_arbiter (NUM_LOCKS=16, ACC_BITS=4).
module tb_ompss_lock_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] cmd_in_tdata = '0;
  logic [3:0]  cmd_in_tid = '0;
  logic        cmd_in_tvalid = 1'b0;
  logic        cmd_in_tready;
  logic [63:0] ack_out_tdata;
  logic [3:0]  ack_out_tdest;
  logic [4:0]  ack_out_tid;
  logic        ack_out_tvalid;
  logic        ack_out_tready = 1'b1;
  logic [8:0]  locks_held;
  logic        err;

  int tests = 0;
  int fails = 0;

  localparam logic [47:0] JUNK = 48'hABCD_EF01_2345;

  always #5 clk = ~clk;

  ompss_lock_arbiter #(.NUM_LOCKS(16), .ACC_BITS(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_in_tdata   (cmd_in_tdata),
    .cmd_in_tid     (cmd_in_tid),
    .cmd_in_tvalid  (cmd_in_tvalid),
    .cmd_in_tready  (cmd_in_tready),
    .ack_out_tdata  (ack_out_tdata),
    .ack_out_tdest  (ack_out_tdest),
    .ack_out_tid    (ack_out_tid),
    .ack_out_tvalid (ack_out_tvalid),
    .ack_out_tready (ack_out_tready),
    .locks_held     (locks_held),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset at the current time and checks the reset values right away.
  // Releases reset just after the next edge, then checks that tready rises.
  task automatic do_reset();
    rstn = 1'b0;
    cmd_in_tvalid = 1'b0;
    #1;
    chk("rst_tready", 64'(cmd_in_tready), 64'd0);
    chk("rst_ack_valid", 64'(ack_out_tvalid), 64'd0);
    chk("rst_ack_data", ack_out_tdata, 64'd0);
    chk("rst_ack_dest", 64'(ack_out_tdest), 64'd0);
    chk("rst_locks", 64'(locks_held), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_tid", 64'(ack_out_tid), 64'h15);
    tick();
    chk("rst_tready_hold", 64'(cmd_in_tready), 64'd0);
    rstn = 1'b1;
    tick();
    chk("rst_tready_rise", 64'(cmd_in_tready), 64'd1);
    $display("[TB] reset done");
  endtask

  // Presents one command and returns just after the accepting edge.
  task automatic send(input logic [3:0] acc, input logic [7:0] code, input logic [7:0] id);
    bit ok;
    ok = 1'b0;
    cmd_in_tdata  = {JUNK, id, code};
    cmd_in_tid    = acc;
    cmd_in_tvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (cmd_in_tready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_in_tvalid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  // Sends a LOCK and checks its ack. If ack_out_tready is high, also checks that
  // the handshake completes and tready returns.
  task automatic do_lock(input logic [3:0] acc, input logic [7:0] id, input bit ok,
                         input logic [8:0] exp_locks, input logic exp_err);
    send(acc, 8'h04, id);
    chk("exec_no_ack", 64'(ack_out_tvalid), 64'd0);
    chk("exec_tready", 64'(cmd_in_tready), 64'd0);
    tick();
    chk("ack_valid", 64'(ack_out_tvalid), 64'd1);
    chk("ack_data", ack_out_tdata, {48'h0, id, 7'h0, ok});
    chk("ack_dest", 64'(ack_out_tdest), 64'(acc));
    chk("ack_tid", 64'(ack_out_tid), 64'h15);
    chk("lock_count", 64'(locks_held), 64'(exp_locks));
    chk("lock_err", 64'(err), 64'(exp_err));
    $display("[TB] LOCK acc=%0d id=0x%0h -> ack 0x%0h locks=%0d err=%0d",
             acc, id, ack_out_tdata, locks_held, err);
    if (ack_out_tready) begin
      tick();
      chk("ack_done", 64'(ack_out_tvalid), 64'd0);
      chk("ack_tready_back", 64'(cmd_in_tready), 64'd1);
    end
  endtask

  // Sends a command that produces no ack: an UNLOCK or an unknown code.
  task automatic do_noack(input logic [3:0] acc, input logic [7:0] code, input logic [7:0] id,
                          input logic [8:0] exp_locks, input logic exp_err);
    send(acc, code, id);
    tick();
    chk("noack_valid", 64'(ack_out_tvalid), 64'd0);
    chk("noack_tready", 64'(cmd_in_tready), 64'd1);
    chk("noack_locks", 64'(locks_held), 64'(exp_locks));
    chk("noack_err", 64'(err), 64'(exp_err));
    $display("[TB] CMD 0x%0h acc=%0d id=0x%0h -> locks=%0d err=%0d",
             code, acc, id, locks_held, err);
  endtask

  initial begin
    // Initial reset.
    do_reset();

    // Grant, then contention, including a re-lock by the current owner.
    do_lock(4'd3, 8'h05, 1'b1, 9'd1, 1'b0);
    do_lock(4'd7, 8'h05, 1'b0, 9'd1, 1'b0);
    do_lock(4'd3, 8'h05, 1'b0, 9'd1, 1'b0);
    do_noack(4'd3, 8'h06, 8'h05, 9'd0, 1'b0);
    do_lock(4'd7, 8'h05, 1'b1, 9'd1, 1'b0);

    // Backpressure: the ack is held for 10 cycles while another command waits.
    ack_out_tready = 1'b0;
    send(4'd1, 8'h04, 8'h0F);
    tick();
    cmd_in_tdata  = {JUNK, 8'h03, 8'h04};
    cmd_in_tid    = 4'd2;
    cmd_in_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(ack_out_tvalid), 64'd1);
      chk("bp_data", ack_out_tdata, 64'h0F01);
      chk("bp_dest", 64'(ack_out_tdest), 64'd1);
      chk("bp_cmd_tready", 64'(cmd_in_tready), 64'd0);
      tick();
    end
    $display("[TB] backpressure held 10 cycles, ack 0x%0h", ack_out_tdata);
    ack_out_tready = 1'b1;
    tick();
    chk("bp_ack_done", 64'(ack_out_tvalid), 64'd0);
    chk("bp_tready_back", 64'(cmd_in_tready), 64'd1);
    tick();
    cmd_in_tvalid = 1'b0;
    chk("bp_next_accepted", 64'(cmd_in_tready), 64'd0);
    tick();
    chk("bp_next_ack", ack_out_tdata, 64'h0301);
    chk("bp_next_dest", 64'(ack_out_tdest), 64'd2);
    chk("bp_next_locks", 64'(locks_held), 64'd3);
    $display("[TB] queued LOCK acc=2 id=0x3 -> ack 0x%0h locks=%0d", ack_out_tdata, locks_held);
    tick();

    // Foreign unlock: flags err and leaves the owner unchanged.
    do_noack(4'd2, 8'h06, 8'h05, 9'd3, 1'b1);
    do_noack(4'd7, 8'h06, 8'h05, 9'd2, 1'b1);
    do_noack(4'd1, 8'h06, 8'h0F, 9'd1, 1'b1);
    do_noack(4'd2, 8'h06, 8'h03, 9'd0, 1'b1);

    // Out-of-range IDs, including the first ID past the table.
    do_reset();
    do_lock(4'd6, 8'h20, 1'b0, 9'd0, 1'b1);
    do_reset();
    do_lock(4'd6, 8'h10, 1'b0, 9'd0, 1'b1);
    // Unknown code.
    do_reset();
    do_noack(4'd4, 8'h09, 8'h01, 9'd0, 1'b1);
    // Unlock of a free entry.
    do_reset();
    do_noack(4'd4, 8'h06, 8'h03, 9'd0, 1'b1);

    // Fill and drain the table.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_lock(4'(i), 8'(i), 1'b1, 9'(i + 1), 1'b0);
    end
    do_lock(4'd5, 8'h00, 1'b0, 9'd16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      do_noack(4'(i), 8'h06, 8'(i), 9'(15 - i), 1'b0);
    end

    // Reset while an ack is stalled in RESP.
    ack_out_tready = 1'b0;
    send(4'd4, 8'h04, 8'h09);
    tick();
    chk("mid_resp_valid", 64'(ack_out_tvalid), 64'd1);
    #3;
    ack_out_tready = 1'b1;
    do_reset();
    do_lock(4'd4, 8'h09, 1'b1, 9'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ompss_lock_arbiter.md
# ompss_lock_arbiter

Arbitrates a table of mutual-exclusion locks shared between FPGA accelerators, sitting in the OmpSs Manager as hardware resource HWR_LOCK_ID (0x15). Accepts lock/unlock commands from the accelerator command interconnect, grants or rejects each lock request, and returns an acknowledgement word to the requester. Each accelerator must own a lock exclusively between its LOCK and its UNLOCK.

## Interface
- NUM_LOCKS, 16, number of lock entries; 1..256.
- ACC_BITS, 4, width of accelerator ID (TID/TDEST).
- clk  in  1  single clock domain.
- rstn  in  1  reset; asynchronous, active-low.
- cmd_in_tdata  in  64  command word: [7:0] code, [15:8] lock ID, rest ignored.
- cmd_in_tid  in  ACC_BITS  issuing accelerator ID.
- cmd_in_tvalid  in  1  command valid.
- cmd_in_tready  out  1  command accepted when tvalid&tready.
- ack_out_tdata  out  64  [7:0] ack code, [15:8] lock ID, [63:16] zero.
- ack_out_tdest  out  ACC_BITS  requesting accelerator ID.
- ack_out_tid  out  5  constant 0x15.
- ack_out_tvalid  out  1  ack valid.
- ack_out_tready  in  1  downstream ready.
- locks_held  out  9  count of currently owned locks.
- err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Lock table: per entry a valid bit and an ACC_BITS owner. Reset: all invalid.
- FSM states IDLE, EXEC, RESP.
- IDLE: cmd_in_tready=1. On handshake latch code, lock ID, TID; go EXEC.
- EXEC (cmd_in_tready=0), by latched code:
  - 0x04 LOCK, ID < NUM_LOCKS, entry invalid: set valid, owner=TID, locks_held+1, ack code 0x01 (OK); go RESP.
  - 0x04 LOCK, entry valid (any owner, including the requester itself): ack 0x00 (REJECT), table unchanged; go RESP. The accelerator retries.
  - 0x04 LOCK, ID >= NUM_LOCKS: ack 0x00, set err; go RESP.
  - 0x06 UNLOCK, entry valid and owner==TID: clear valid, locks_held-1; no ack; go IDLE.
  - 0x06 UNLOCK, entry invalid, owner!=TID, or ID out of range: table unchanged, set err; no ack; go IDLE.
  - Any other code: drop, set err; go IDLE.
- RESP: ack_out_tvalid=1, data/tdest stable until ack_out_tready; on handshake go IDLE.
- Commands are served strictly in acceptance order; no command is accepted while one is in EXEC or RESP (no reordering, no bypass).
- locks_held never wraps: it is bounded by NUM_LOCKS by construction.
- Lock ID bits beyond log2(NUM_LOCKS) are compared, not truncated. For example, ID 0x10 with NUM_LOCKS=16 is out of range.

## Timing
- Reset (rstn low, any state, including mid-RESP): state IDLE, cmd_in_tready=0 while rstn low, ack_out_tvalid=0, ack_out_tdata=0, ack_out_tdest=0, locks_held=0, err=0, table cleared. A pending ack is discarded.
- ack_out_tid is constant 0x15 in and out of reset.
- cmd_in_tready is registered, asserting the first cycle after rstn deasserts.
- Lock command accepted at cycle N: table updated and ack_out_tvalid high at N+2. The next command can be accepted at the cycle after the ack handshake, which is N+3 at the earliest.
- Unlock accepted at N: table and locks_held update at N+2, cmd_in_tready high at N+2. Peak throughput is one unlock every 2 cycles.
- err and locks_held are registered outputs, updated at the EXEC→next edge.
- Backpressure: ack_out_tvalid must not drop and ack_out_tdata must not change until ack_out_tready.

## Test plan
- Grant: acc 3 LOCK id 5 (tdata 0x0504), tready=1 -> ack at +2: tdata 0x0501, tdest 3, tid 0x15, locks_held 1.
- Contention: acc 3 holds id 5, acc 7 LOCK id 5 -> ack 0x0500 to tdest 7. Acc 3 UNLOCK id 5, then acc 7 LOCK id 5 -> 0x0501, locks_held 1.
- Errors: acc 2 UNLOCK id 5 owned by acc 3 -> no ack, err=1, owner unchanged. LOCK id 0x20 (NUM_LOCKS=16) -> ack 0x2000, err=1. Code 0x09 -> dropped, err=1.
- Backpressure: hold ack_out_tready=0 for 10 cycles after a grant -> ack stable, cmd_in_tready=0 throughout, next command accepted only after the handshake.
- Fill/drain: 16 accelerators × distinct IDs 0..15 all granted, locks_held=16; all unlocked -> locks_held=0, err=0.
- Reset mid-RESP: assert rstn during a stalled ack -> ack_out_tvalid=0 immediately. After release, LOCK on the previously held ID is granted.
